// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, result field layout and FSM states for the FFT peak finder
package fft_pkg;

  localparam int NFFT_LOG2_DEF = 10;

  localparam int RES_IDX_LSB  = 0;
  localparam int RES_PWR_LSB  = 16;
  localparam int RES_LEN_ERR  = 63;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/cplx_mag_sq.sv
// rtl/cplx_mag_sq.sv - registered re^2/im^2 stage with combinational unsigned sum
module cplx_mag_sq (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic signed [15:0] i_re,
  input  logic signed [15:0] i_im,
  output logic               o_valid,
  output logic [31:0]        o_power
);

  logic signed [31:0] w_re_sq;
  logic signed [31:0] w_im_sq;
  logic [31:0]        r_re_sq;
  logic [31:0]        r_im_sq;
  logic               r_valid;

  assign w_re_sq = i_re * i_re;
  assign w_im_sq = i_im * i_im;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_re_sq <= '0;
      r_im_sq <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_re_sq <= w_re_sq;
        r_im_sq <= w_im_sq;
      end
    end
  end

  // Each square is at most 2^30, so the 32-bit unsigned sum cannot wrap.
  assign o_power = r_re_sq + r_im_sq;
  assign o_valid = r_valid;

endmodule

// File: rtl/fft_peak_finder.sv
// rtl/fft_peak_finder.sv - per-frame |X[k]|^2 peak search with frame-length check
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
  parameter bit SKIP_DC   = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic [15:0] s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [63:0] m_axis_peak_tdata,
  output logic        m_axis_peak_tvalid,
  input  logic        m_axis_peak_tready
);

  localparam int CNT_W = NFFT_LOG2 + 2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** NFFT_LOG2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 ** NFFT_LOG2 + 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_run;
  logic   r_drain;
  logic   w_tready;
  logic   w_mvalid;
  logic   w_load_res;

  logic                 w_s_hs;
  logic                 w_m_hs;
  logic [NFFT_LOG2-1:0] w_idx;
  logic                 w_elig;
  logic                 w_unused_tuser;

  logic                 w_pwr_valid;
  logic [31:0]          w_pwr;
  logic [NFFT_LOG2-1:0] r_s1_idx;
  logic                 r_s1_elig;
  logic                 w_take;

  logic                 r_have;
  logic [31:0]          r_max_pwr;
  logic [NFFT_LOG2-1:0] r_max_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 r_len_err;
  logic [63:0]          r_res;

  assign w_s_hs         = s_axis_tvalid & w_tready;
  assign w_m_hs         = w_mvalid & m_axis_peak_tready;
  assign w_idx          = s_axis_tuser[NFFT_LOG2-1:0];
  assign w_elig         = !(SKIP_DC && (w_idx == '0));
  assign w_unused_tuser = ^s_axis_tuser;

  cplx_mag_sq u_mag (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_valid (w_s_hs),
    .i_re    (s_axis_tdata[15:0]),
    .i_im    (s_axis_tdata[31:16]),
    .o_valid (w_pwr_valid),
    .o_power (w_pwr)
  );

  // Bin index and eligibility ride alongside the squares stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_idx  <= '0;
      r_s1_elig <= 1'b0;
    end else begin
      r_s1_elig <= w_s_hs & w_elig;
      if (w_s_hs) r_s1_idx <= w_idx;
    end
  end

  assign w_take = w_pwr_valid & r_s1_elig & (!r_have | (w_pwr > r_max_pwr));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_have    <= 1'b0;
      r_max_pwr <= '0;
      r_max_idx <= '0;
    end else if (w_m_hs) begin
      r_have    <= 1'b0;
      r_max_pwr <= '0;
      r_max_idx <= '0;
    end else if (w_take) begin
      r_have    <= 1'b1;
      r_max_pwr <= w_pwr;
      r_max_idx <= r_s1_idx;
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_m_hs) r_cnt <= '0;
      else if (w_s_hs) r_cnt <= w_cnt_inc;
      if (w_s_hs && s_axis_tlast) r_len_err <= (w_cnt_inc != CNT_FULL);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_res <= '0;
    end else if (w_load_res) begin
      r_res                                <= '0;
      r_res[RES_IDX_LSB +: NFFT_LOG2]      <= r_max_idx;
      r_res[RES_PWR_LSB +: 32]             <= r_max_pwr;
      r_res[RES_LEN_ERR]                   <= r_len_err;
    end
  end

  // r_run holds tready low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_ACC;
      r_run   <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b0;
    w_mvalid    = 1'b0;
    w_load_res  = 1'b0;
    case (r_state)
      ST_ACC: begin
        w_tready = r_run;
        if (s_axis_tvalid && r_run && s_axis_tlast) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain) begin
          w_state_nxt = ST_OUT;
          w_load_res  = 1'b1;
        end
      end
      ST_OUT: begin
        w_mvalid = 1'b1;
        if (m_axis_peak_tready) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  assign s_axis_tready      = w_tready;
  assign m_axis_peak_tvalid = w_mvalid;
  assign m_axis_peak_tdata  = r_res;

endmodule

// File: tb/tb_fft_peak_finder.sv
// tb/tb_fft_peak_finder.sv - directed bench for fft_peak_finder with SKIP_DC=1 and SKIP_DC=0 instances
module tb_fft_peak_finder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] tdata = '0;
  logic [15:0] tuser = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        m_tready = 1'b0;

  logic        rdy1, rdy0;
  logic [63:0] pk1, pk0;
  logic        pv1, pv0;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  fft_peak_finder #(.NFFT_LOG2(10), .SKIP_DC(1'b1)) u_dut1 (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_tdata       (tdata),
    .s_axis_tuser       (tuser),
    .s_axis_tvalid      (tvalid),
    .s_axis_tready      (rdy1),
    .s_axis_tlast       (tlast),
    .m_axis_peak_tdata  (pk1),
    .m_axis_peak_tvalid (pv1),
    .m_axis_peak_tready (m_tready)
  );

  fft_peak_finder #(.NFFT_LOG2(10), .SKIP_DC(1'b0)) u_dut0 (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_tdata       (tdata),
    .s_axis_tuser       (tuser),
    .s_axis_tvalid      (tvalid),
    .s_axis_tready      (rdy0),
    .s_axis_tlast       (tlast),
    .m_axis_peak_tdata  (pk0),
    .m_axis_peak_tvalid (pv0),
    .m_axis_peak_tready (m_tready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pk(input int idx, input logic [31:0] pwr, input bit err);
    return {err, 15'd0, pwr, 16'(idx)};
  endfunction

  function automatic logic [31:0] beat_data(input int pat, input int k);
    case (pat)
      0: return (k == 37) ? {16'hF830, 16'd1000} : {16'd1, 16'd1};
      1: return (k == 5 || k == 9) ? {16'd400, 16'd300} : 32'd0;
      2: return (k == 0) ? {16'h7FFF, 16'h7FFF} : (k == 1) ? {16'd0, 16'd10} : 32'd0;
      3: return 32'h8000_8000;
      default: return (k == 0) ? {16'd4, 16'd3} : 32'd0;
    endcase
  endfunction

  task automatic send_frame(input int pat, input int len, input int rst_at);
    int  k;
    int  guard;
    logic acc;
    k = 0;
    guard = 0;
    while (k < len) begin
      if (k == rst_at) begin
        tvalid  = 1'b0;
        tlast   = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tready", 64'(rdy1), 64'd0);
        check("rst_mvalid", 64'(pv1), 64'd0);
        aresetn = 1'b1;
        #1;
        check("rel_tready", 64'(rdy1), 64'd0);
        @(posedge aclk);
        #1;
        check("run_tready", 64'(rdy1), 64'd1);
        return;
      end
      tvalid = 1'b1;
      tdata  = beat_data(pat, k);
      tuser  = 16'(k);
      tlast  = (k == len - 1);
      acc    = rdy1;
      @(posedge aclk);
      #1;
      if (acc) k++;
      guard++;
      if (guard > len + 50) begin
        n_vec++;
        n_err++;
        $error("FAIL frame_timeout: observed %0d beats expected %0d", k, len);
        tvalid = 1'b0;
        tlast  = 1'b0;
        return;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [63:0] e1, input logic [63:0] e0,
                            input int stall);
    int waited;
    waited = 0;
    while (pv1 !== 1'b1 && waited < 20) begin
      @(posedge aclk);
      #1;
      waited++;
    end
    check({tag, "_lat"}, 64'(waited), 64'd2);
    check({tag, "_skip"}, pk1, e1);
    check({tag, "_noskip"}, pk0, e0);
    check({tag, "_v0"}, 64'(pv0), 64'd1);
    repeat (stall) begin
      @(posedge aclk);
      #1;
      check({tag, "_stall_rdy"}, 64'(rdy1), 64'd0);
      check({tag, "_stall_v"}, 64'(pv1), 64'd1);
      check({tag, "_stall_d"}, pk1, e1);
    end
    check({tag, "_busy"}, 64'(rdy1), 64'd0);
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    m_tready = 1'b0;
    check({tag, "_rdy_back"}, 64'(rdy1), 64'd1);
    check({tag, "_v_drop"}, 64'(pv1), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("reset_tready", 64'(rdy1), 64'd0);
    check("reset_mvalid", 64'(pv1), 64'd0);
    check("reset_mdata", pk1, 64'd0);
    aresetn = 1'b1;
    #1;
    check("release_tready", 64'(rdy1), 64'd0);
    @(posedge aclk);
    #1;
    check("first_tready", 64'(rdy1), 64'd1);

    send_frame(0, 1024, -1);
    get_result("bin37", pk(37, 32'd5000000, 1'b0), pk(37, 32'd5000000, 1'b0), 0);

    send_frame(1, 1024, -1);
    get_result("tie", pk(5, 32'd250000, 1'b0), pk(5, 32'd250000, 1'b0), 0);

    send_frame(2, 1024, -1);
    get_result("dc", pk(1, 32'd100, 1'b0), pk(0, 32'd2147352578, 1'b0), 0);

    send_frame(3, 1024, -1);
    get_result("most_neg", pk(1, 32'h8000_0000, 1'b0), pk(0, 32'h8000_0000, 1'b0), 0);

    send_frame(0, 512, -1);
    get_result("short", pk(37, 32'd5000000, 1'b1), pk(37, 32'd5000000, 1'b1), 20);

    send_frame(4, 1, -1);
    get_result("single", pk(0, 32'd0, 1'b1), pk(0, 32'd25, 1'b1), 0);

    send_frame(1, 1024, 300);
    repeat (5) begin
      @(posedge aclk);
      #1;
      check("rst_no_result", 64'(pv1), 64'd0);
    end
    send_frame(2, 1024, -1);
    get_result("post_rst", pk(1, 32'd100, 1'b0), pk(0, 32'd2147352578, 1'b0), 0);
    repeat (5) begin
      @(posedge aclk);
      #1;
      check("no_extra", 64'(pv1 | pv0), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Streaming consumer placed directly downstream of the FFT core's master data port. Takes one complex spectrum frame (one beat per bin, framed by tlast), computes |X[k]|² per bin, tracks the strongest bin, and emits one result beat per frame with peak index, peak power and a frame-length error flag. Its ready output drives the FFT core's m_axis_data_tready.

## Interface
- NFFT_LOG2, 10: log2 of expected frame length; bin index taken from s_axis_tuser[NFFT_LOG2-1:0].
- SKIP_DC, 1: when 1, beats with bin index 0 are excluded from the peak search.
- aclk  in  1  single clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  32  [15:0] real, [31:16] imag, both signed two's complement.
- s_axis_tuser  in  16  FFT output bin index (XK_INDEX), low NFFT_LOG2 bits used.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when tvalid & tready.
- s_axis_tlast  in  1  last bin of frame.
- m_axis_peak_tdata  out  64  [15:0] peak index (zero-extended), [47:16] peak power (unsigned), [62:48] zero, [63] len_err.
- m_axis_peak_tvalid  out  1  result valid.
- m_axis_peak_tready  in  1  downstream accepts result.

## Operation
- Power: re*re + im*im, each product signed 16x16 -> 32-bit, sum unsigned 32-bit; max (-32768,-32768) = 2^31, no overflow, no rounding.
- Eligible beat: any accepted beat, except index 0 when SKIP_DC=1.
- First eligible beat of a frame loads running max unconditionally; later eligible beats replace it only if power is strictly greater (ties keep the lower-arrival, i.e. earlier, bin).
- No eligible beat in frame: result index 0, power 0.
- Beat counter counts accepted beats in frame, saturating at 2^NFFT_LOG2+1; len_err = 1 when count at tlast != 2^NFFT_LOG2. Frames longer than NFFT without tlast keep accumulating until tlast.
- FSM states:
  - ACC: s_axis_tready=1; tlast handshake -> DRAIN.
  - DRAIN: s_axis_tready=0, 2 cycles while pipeline completes -> OUT.
  - OUT: m_axis_peak_tvalid=1, s_axis_tready=0; m handshake -> ACC with max/counter/first-flag cleared.
- tdata held stable while tvalid high and not accepted.

## Timing
- Reset values: s_axis_tready=0 while aresetn low, 1 from first edge after release (state ACC); m_axis_peak_tvalid=0; m_axis_peak_tdata=0; internal max, counter, pipeline valid bits cleared.
- Pipeline: beat accepted at edge E0 -> squares registered at E0 -> sum/compare registered at E1 -> result register loaded at E2; m_axis_peak_tvalid high from E2 for tlast beat.
- s_axis_tready low from cycle after tlast handshake through cycle of output handshake; high again on next cycle.
- Min gap between frames: 3 cycles + downstream stall.
- Reset asserted mid-frame or in OUT: partial frame and pending result discarded, no output beat.
- Single-beat frame (tvalid+tlast on first beat): handled identically, len_err=1 unless NFFT_LOG2=0.

## Structure
- Shared package fft_pkg: default NFFT_LOG2, result field bit positions (index lsb, power lsb, len_err bit), FSM state enum.
- Sub-module cplx_mag_sq: registered squares stage plus combinational sum, 32-bit unsigned power out with valid; instantiated once.

## Test plan
- 1024-beat frame, bin 37 = (1000, -2000), others (1,1), tlast on index 1023 -> one result: index 37, power 5,000,000, len_err 0.
- Bins 5 and 9 both (300,400), rest 0 -> index 5, power 250,000 (tie keeps earlier).
- SKIP_DC=1, bin 0 = (32767,32767), bin 1 = (10,0), rest 0 -> index 1, power 100; with SKIP_DC=0 -> index 0, power 2,147,352,578.
- All bins (-32768,-32768) -> power 2,147,483,648, index 1 (SKIP_DC=1), no overflow.
- Frame with tlast at beat 512 -> len_err 1; hold m_axis_peak_tready=0 for 20 cycles -> s_axis_tready stays 0, tdata stable, then one handshake and s_axis_tready returns 1 next cycle.
- aresetn pulsed low at beat 300 of a frame -> no result beat; following full frame produces exactly one correct result.
